// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets, bus encodings and defaults shared by the interrupt controller
package int_ctrl_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_CAUSE   = 2'd2;
    localparam logic [1:0] REG_EDGE    = 2'd3;

    localparam logic [31:0] DEF_BASE       = 32'h0000_0F00;
    localparam logic [31:0] DEF_VEC        = 32'h0000_040C;
    localparam logic [31:0] DEF_CAUSE_BASE = 32'h0000_0010;

    typedef enum logic [1:0] {
        MW_NONE = 2'd0,
        MW_WORD = 2'd1,
        MW_DMA  = 2'd2,
        MW_BYTE = 2'd3
    } mw_e;

    // Index of the lowest set bit; 0 when none is set (callers qualify with |v).
    function automatic logic [4:0] lowest_idx(input logic [15:0] v);
        lowest_idx = 5'd0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) lowest_idx = 5'(i);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: per-bit two-flop synchroniser followed by a delay flop for rise detection
module irq_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] lvl_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] s1_q, s2_q, dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= '0;
            s2_q  <= '0;
            dly_q <= '0;
        end else begin
            s1_q  <= d_i;
            s2_q  <= s1_q;
            dly_q <= s2_q;
        end
    end

    assign lvl_o  = s2_q;
    assign rise_o = s2_q & ~dly_q;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: bus-mapped interrupt controller; latches edge/level requests, masks them
// and presents the lowest-index active source to the CPU as a cause number.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NSRC       = 8,
    parameter logic [31:0] BASE       = DEF_BASE,
    parameter logic [31:0] VEC        = DEF_VEC,
    parameter logic [31:0] CAUSE_BASE = DEF_CAUSE_BASE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    input  logic [31:0]     Addr,
    input  logic            Memread,
    input  logic [1:0]      Memwrite,
    inout  wire  [31:0]     BUS,
    output logic            INTin,
    output logic [31:0]     INTnum
);

    logic [NSRC-1:0] lvl, rise, active, w1c, ack_clr, wdata;
    logic [NSRC-1:0] pend_q, pend_d, mask_q, mask_d, edge_mode_q, edge_mode_d;
    logic [31:0]     cause_q, cause_d, intnum_q, intnum_d, offs, ack_idx, rdata;
    logic            intin_q, intin_d, wr_seen_q, wr_seen_d, ack_seen_q, ack_seen_d;
    logic            hit, wr_req, commit, rd_en, ack_hit, ack;
    logic            unused_bus;
    mw_e             mw;

    irq_sync #(.W(NSRC)) u_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (src),
        .lvl_o  (lvl),
        .rise_o (rise)
    );

    assign mw         = mw_e'(Memwrite);
    assign offs       = Addr - BASE;
    assign hit        = offs[31:2] == 30'd0;
    assign wdata      = BUS[NSRC-1:0];
    assign unused_bus = ^BUS;
    assign active     = pend_q & ~mask_q;

    // Memwrite is held for several cycles; only the first hitting cycle commits.
    assign wr_req  = hit && (mw == MW_WORD || mw == MW_BYTE);
    assign commit  = wr_req && !wr_seen_q;
    assign ack_hit = Memread && Addr == VEC;
    assign ack     = ack_hit && !ack_seen_q;
    assign ack_idx = intnum_q - CAUSE_BASE;

    always_comb begin
        ack_clr = '0;
        for (int k = 0; k < NSRC; k++)
            ack_clr[k] = ack && (|active) && ack_idx == k && edge_mode_q[k];
    end

    always_comb begin
        mask_d      = (commit && offs[1:0] == REG_MASK) ? wdata : mask_q;
        edge_mode_d = (commit && offs[1:0] == REG_EDGE) ? wdata : edge_mode_q;
        w1c         = (commit && offs[1:0] == REG_PENDING) ? wdata & edge_mode_q : '0;
        // A new rising edge beats any clear arriving in the same cycle.
        pend_d      = (edge_mode_q & ((pend_q & ~w1c & ~ack_clr) | rise)) | (~edge_mode_q & lvl);
        cause_d     = ack ? intnum_q : cause_q;
        intin_d     = |active;
        intnum_d    = (|active) ? CAUSE_BASE + {27'd0, lowest_idx(16'(active))} : intnum_q;
        wr_seen_d   = commit ? 1'b1 : (mw == MW_NONE) ? 1'b0 : wr_seen_q;
        ack_seen_d  = ack_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= '0;
            mask_q      <= '1;
            edge_mode_q <= '1;
            cause_q     <= '0;
            intin_q     <= 1'b0;
            intnum_q    <= '0;
            wr_seen_q   <= 1'b0;
            ack_seen_q  <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            edge_mode_q <= edge_mode_d;
            cause_q     <= cause_d;
            intin_q     <= intin_d;
            intnum_q    <= intnum_d;
            wr_seen_q   <= wr_seen_d;
            ack_seen_q  <= ack_seen_d;
        end
    end

    always_comb begin
        rdata = offs[1:0] == REG_PENDING ? 32'(pend_q) :
                offs[1:0] == REG_MASK    ? 32'(mask_q) :
                offs[1:0] == REG_CAUSE   ? cause_q     : 32'(edge_mode_q);
    end

    assign rd_en  = Memread && mw == MW_NONE && hit;
    assign BUS    = rd_en ? rdata : 'z;
    assign INTin  = intin_q;
    assign INTnum = intnum_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed vectors with hand-computed expectations for int_ctrl
module tb_int_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0F00;
    localparam logic [31:0] VEC  = 32'h0000_040C;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  src;
    logic [31:0] Addr;
    logic        Memread;
    logic [1:0]  Memwrite;
    wire  [31:0] BUS;
    logic        INTin;
    logic [31:0] INTnum;
    logic [31:0] bus_drv;
    logic        bus_oe;
    int          nvec = 0;
    int          nerr = 0;

    assign BUS = bus_oe ? bus_drv : 'z;

    always #5 clk = ~clk;

    int_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .src      (src),
        .Addr     (Addr),
        .Memread  (Memread),
        .Memwrite (Memwrite),
        .BUS      (BUS),
        .INTin    (INTin),
        .INTnum   (INTnum)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        Addr    = BASE + 32'(off);
        Memread = 1'b1;
        #1 check(tag, BUS, exp);
        @(negedge clk);
        Memread = 1'b0;
        Addr    = '0;
    endtask

    task automatic wr(input logic [1:0] mw, input logic [1:0] off, input logic [31:0] d, input int n);
        Addr     = BASE + 32'(off);
        Memwrite = mw;
        bus_drv  = d;
        bus_oe   = 1'b1;
        cyc(n);
        Memwrite = 2'd0;
        bus_oe   = 1'b0;
        Addr     = '0;
        cyc(1);
    endtask

    task automatic ack(input int n);
        Addr    = VEC;
        Memread = 1'b1;
        cyc(n);
        Memread = 1'b0;
        Addr    = '0;
        cyc(1);
    endtask

    initial begin
        rst = 1'b0; src = '0; Addr = '0; Memread = 1'b0; Memwrite = 2'd0;
        bus_drv = '0; bus_oe = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src = (i % 2 == 0) ? 8'hFF : 8'h00;
            cyc(1);
        end
        src = '0;
        check("rst_intin", {31'd0, INTin}, 32'd0);
        check("rst_intnum", INTnum, 32'd0);
        rst = 1'b1;
        cyc(3);
        rd_chk("rst_mask", 2'd1, 32'hFF);
        rd_chk("rst_edge", 2'd3, 32'hFF);
        rd_chk("rst_pend", 2'd0, 32'h0);
        rd_chk("rst_cause", 2'd2, 32'h0);

        // edge request, 4-edge latency
        wr(2'd1, 2'd1, 32'hFE, 1);
        src[0] = 1'b1;
        cyc(1);
        src[0] = 1'b0;
        cyc(2);
        check("edge_lat3", {31'd0, INTin}, 32'd0);
        cyc(1);
        check("edge_lat4", {31'd0, INTin}, 32'd1);
        check("edge_num", INTnum, 32'h10);
        rd_chk("edge_pend", 2'd0, 32'h1);

        // priority and single ack
        wr(2'd1, 2'd0, 32'h1, 1);
        rd_chk("w1c_pend", 2'd0, 32'h0);
        wr(2'd1, 2'd1, 32'h0, 1);
        src = 8'h24;
        cyc(1);
        src = '0;
        cyc(3);
        check("prio_intin", {31'd0, INTin}, 32'd1);
        check("prio_num", INTnum, 32'h12);
        ack(3);
        check("ack_nextnum", INTnum, 32'h15);
        rd_chk("ack_cause", 2'd2, 32'h12);
        rd_chk("ack_pend", 2'd0, 32'h20);

        // level mode
        wr(2'd1, 2'd3, 32'h0, 1);
        src[3] = 1'b1;
        cyc(4);
        check("lvl_intin", {31'd0, INTin}, 32'd1);
        check("lvl_num", INTnum, 32'h13);
        ack(2);
        cyc(2);
        check("lvl_ack_intin", {31'd0, INTin}, 32'd1);
        rd_chk("lvl_cause", 2'd2, 32'h13);
        wr(2'd1, 2'd0, 32'h8, 1);
        rd_chk("lvl_w1c", 2'd0, 32'h8);
        src[3] = 1'b0;
        cyc(3);
        check("lvl_drop3", {31'd0, INTin}, 32'd1);
        cyc(1);
        check("lvl_drop4", {31'd0, INTin}, 32'd0);
        check("lvl_numhold", INTnum, 32'h13);

        // write qualification: held write commits once, set beats clear
        wr(2'd1, 2'd3, 32'hFF, 1);
        src[0] = 1'b1;
        cyc(1);
        src[0] = 1'b0;
        cyc(3);
        rd_chk("wq_pre", 2'd0, 32'h1);
        Addr = BASE; Memwrite = 2'd1; bus_drv = 32'h1; bus_oe = 1'b1;
        src[0] = 1'b1;
        cyc(1);
        src[0] = 1'b0;
        cyc(3);
        Memwrite = 2'd0; bus_oe = 1'b0; Addr = '0;
        cyc(1);
        rd_chk("wq_once", 2'd0, 32'h1);
        src[0] = 1'b1;
        cyc(1);
        src[0] = 1'b0;
        cyc(1);
        wr(2'd1, 2'd0, 32'h1, 1);
        rd_chk("wq_setwins", 2'd0, 32'h1);
        wr(2'd2, 2'd1, 32'h5A, 2);
        rd_chk("wq_dma", 2'd1, 32'h0);
        wr(2'd3, 2'd1, 32'hF0, 1);
        rd_chk("wq_byte", 2'd1, 32'hF0);
        cyc(1);
        check("wq_intin", {31'd0, INTin}, 32'd1);
        check("wq_num", INTnum, 32'h10);

        // mid-operation reset
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check("mid_intin", {31'd0, INTin}, 32'd0);
        check("mid_intnum", INTnum, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc(1);
        rd_chk("mid_mask", 2'd1, 32'hFF);
        rd_chk("mid_edge", 2'd3, 32'hFF);
        rd_chk("mid_pend", 2'd0, 32'h0);
        rd_chk("mid_cause", 2'd2, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
